mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the Datapath's fetch and data interfaces and the single memory, replacing separate instruction and data memories.
- FSM-sequenced with registered memory-side outputs, round-robin tie-break and a wait-timeout guard.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_WAIT, 16, maximum cycles mem_req may stay high without mem_ready before abort; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request (level)
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse
- err  out  1  timeout flag; pulses with the aborted transaction's valid
- busy  out  1  high whenever state != IDLE
- mem_req, mem_we  out  1  memory request / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  DATA_W  valid when mem_ready=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state=IDLE; wait counter=0; last_grant=G_FETCH.
- States: IDLE, GRANT_D, GRANT_I, RESP.
- IDLE (arbitration):
  - Requests are sampled only in IDLE; a req high in IDLE is always a new transaction.
  - Only d_req: go to GRANT_D. Only if_req: go to GRANT_I.
  - Both: grant the requester not named by last_grant, then update last_grant.
  - On grant, register mem_addr, mem_we, mem_wdata and mem_be from the winner, and set mem_req=1 in the next cycle.
  - For fetches, mem_we=0, mem_be=all ones, mem_wdata=0.
- GRANT_D / GRANT_I:
  - mem_req and all mem_* outputs are held stable until completion.
  - On mem_ready=1: drop mem_req next cycle and go to RESP.
    - Fetch: capture mem_rdata into if_rdata.
    - Load: capture mem_rdata into d_rdata.
    - Store: d_rdata is left unchanged.
  - The wait counter increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches MAX_WAIT-1 with mem_ready still 0: drop mem_req, go to RESP with err armed; the corresponding rdata is loaded with 0.
- RESP:
  - The granted requester's valid is high for exactly one cycle; err is high in the same cycle if armed.
  - Counter is cleared. Next state is IDLE unconditionally; no arbitration in RESP.
- Latency:
  - req seen in IDLE at cycle t → mem_req high from t+1.
  - mem_ready at t+1+k → valid at t+2+k → IDLE at t+3+k.
  - Minimum req-to-valid is 2 cycles.
- Requester rule: deassert req in the cycle its valid is high, unless issuing a new request. The arbiter never re-grants during RESP.
- if_rdata and d_rdata hold their last value between valids.
- Only one of if_valid and d_valid is ever high in a cycle.
- Reset mid-transaction: the next cycle state=IDLE and mem_req=0. No valid or err is issued for the abandoned access; the memory must tolerate a dropped request.
- mem_ready while mem_req=0 is ignored.
- Width rules: counter is $clog2(MAX_WAIT+1) bits and saturates; it never wraps.

Decomposition:
- Package riscv_mem_pkg:
  - arb_state_t enum {IDLE, GRANT_D, GRANT_I, RESP}.
  - grant_t enum {G_FETCH, G_DATA}.
  - Constant BE_ALL_ONES function of DATA_W.
- One sub-module: mem_wait_timer, the counter plus timeout compare.
  - Inputs: clk, reset, clear, count_en.
  - Output: expired.

Test Plan:
- Reset held 2 cycles mid-idle → all outputs 0, busy=0; first tie after reset grants data.
- Fetch only: if_addr=0x00000010, mem_ready after 2 wait cycles with mem_rdata=0x00500093 → mem_addr=0x10, mem_we=0; if_valid one pulse 4 cycles after request; if_rdata=0x00500093.
- Continuous if_req=d_req=1, mem_ready=1 always → grants alternate D,I,D,I; each valid one cycle; no cycle with both valids.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF → mem_we=1 with those values held until mem_ready; d_valid pulses; d_rdata unchanged from prior load.
- MAX_WAIT=4, load with mem_ready stuck 0 → mem_req high exactly 4 cycles; d_valid and err pulse together; d_rdata=0; then IDLE.
- Reset asserted in GRANT_I with mem_req=1 → next cycle mem_req=0, busy=0; no if_valid follows.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified fetch/data memory port arbiter.
// Imported by the arbiter top and its wait timer.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_D,
    GRANT_I,
    RESP
  } arb_state_t;

  typedef enum logic {
    G_FETCH,
    G_DATA
  } grant_t;

  // All byte lanes enabled for a DATA_W-bit word (DATA_W up to 504).
  function automatic logic [63:0] be_all_ones(int unsigned data_w);
    return (64'd1 << (data_w / 8)) - 64'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory port.
// master: the arbiter; slave: the core requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              err;
  logic              busy;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_valid,
    output err, busy,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_valid,
    input  err, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating wait counter with timeout compare for the memory port.
// expired is high while the count sits at MAX_WAIT-1.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count_en && cnt != CW'(MAX_WAIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port
// between instruction fetch and load/store, with wait timeout.
import riscv_mem_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL_ONES =
    BE_W'(be_all_ones(DATA_W));

  arb_state_t        state;
  grant_t            last_grant;
  logic              err_armed;
  logic              expired;
  logic              pick_d;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic [DATA_W-1:0] rsp_data;

  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;

  // On a tie the data side wins unless it had the previous grant.
  assign pick_d = bus.d_req &&
                  (!bus.if_req || last_grant == G_FETCH);

  always_comb begin
    win_we    = 1'b0;
    win_addr  = bus.if_addr;
    win_wdata = '0;
    win_be    = BE_ALL_ONES;
    unique case (1'b1)
      pick_d: begin
        win_we    = bus.d_we;
        win_addr  = bus.d_addr;
        win_wdata = bus.d_wdata;
        win_be    = bus.d_be;
      end
      default: ;
    endcase
  end

  assign rsp_data = bus.mem_ready ? bus.mem_rdata : '0;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == RESP),
    .count_en (mem_req && !bus.mem_ready),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= G_FETCH;
      err_armed  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.d_req || bus.if_req) begin
            state      <= pick_d ? GRANT_D : GRANT_I;
            last_grant <= pick_d ? G_DATA : G_FETCH;
            mem_req    <= 1'b1;
            mem_we     <= win_we;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
            mem_be     <= win_be;
          end
        end
        GRANT_D, GRANT_I: begin
          if (bus.mem_ready || expired) begin
            mem_req   <= 1'b0;
            state     <= RESP;
            err_armed <= !bus.mem_ready;
            if (state == GRANT_I) begin
              if_rdata <= rsp_data;
            end else if (!mem_we || !bus.mem_ready) begin
              d_rdata <= rsp_data;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          err_armed <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_be    = mem_be;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.if_valid  = (state == RESP) && (last_grant == G_FETCH);
  assign bus.d_valid   = (state == RESP) && (last_grant == G_DATA);
  assign bus.err       = (state == RESP) && err_armed;
  assign bus.busy      = (state != IDLE);

endmodule
